track_scheduler: RTL and testbench
==================================

TRACK_SCHEDULER -- requirements
Module: track_scheduler

Interface
REQ-001 Parameter IDX_W, default 3: track index width; track count N = 2^IDX_W.
REQ-002 Parameter LOCKOUT, default 500000: cycles PREV/NEXT are ignored after an accepted PREV/NEXT.
REQ-003 CLK  in  1  system clock; all state updates on rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 PREV  in  1  level, debounced "previous track" button.
REQ-006 NEXT  in  1  level, debounced "next track" button.
REQ-007 PLAY_TOGGLE  in  1  single-cycle pulse, play/pause request.
REQ-008 MODE  in  2  play mode: 0 sequential-stop, 1 loop-all, 2 repeat-one, 3 shuffle.
REQ-009 TRACK_END  in  1  single-cycle pulse from decoder, current track finished.
REQ-010 LOAD_ACK  in  1  loader accepted TRACK; meaningful only while LOAD_REQ=1.
REQ-011 TRACK  out  IDX_W  registered selected track index.
REQ-012 LOAD_REQ  out  1  registered request to load TRACK.
REQ-013 PLAYING  out  1  registered; 1 only in state PLAY.
REQ-014 BUSY  out  1  registered; 1 only in state LOAD.

Function
REQ-015 FSM states IDLE, LOAD, PLAY, PAUSE; a 1-bit resume flag selects PLAY or PAUSE on leaving LOAD.
REQ-016 Lockout counter: PREV/NEXT accepted only when counter = 0 and not in LOAD; on acceptance it loads LOCKOUT and then decrements by 1 per cycle until 0.
REQ-017 Per-cycle event priority: PREV > NEXT > TRACK_END > PLAY_TOGGLE; at most one event is acted on per cycle, and lower-priority events in that cycle are dropped.
REQ-018 PREV: TRACK <= TRACK-1 mod N (0 wraps to N-1). NEXT: TRACK <= next-track rule (REQ-020). Both rules apply in every mode.
REQ-019 PREV/NEXT in IDLE: update TRACK only; no load, state stays IDLE. In PLAY: update TRACK, go to LOAD with resume=PLAY. In PAUSE: update TRACK, go to LOAD with resume=PAUSE.
REQ-020 Next-track rule: MODE 0/1/2 -> TRACK+1 mod N. MODE 3 -> candidate = LFSR[IDX_W-1:0]; if candidate = TRACK, use TRACK+1 mod N instead.
REQ-021 TRACK_END is acted on only in PLAY. MODE 0: if TRACK = N-1, TRACK <= 0 and state goes to IDLE with no load; otherwise next-track rule, then LOAD with resume=PLAY. MODE 1/3: next-track rule, then LOAD. MODE 2: TRACK unchanged, then LOAD with resume=PLAY.
REQ-022 PLAY_TOGGLE: IDLE -> LOAD (resume=PLAY); PLAY -> PAUSE; PAUSE -> PLAY; ignored in LOAD.
REQ-023 Entering LOAD sets LOAD_REQ=1 and BUSY=1 on the same edge that updates TRACK (zero added latency).
REQ-024 In LOAD, LOAD_REQ stays 1 and TRACK is held stable until LOAD_ACK is sampled 1. On that edge LOAD_REQ=0, BUSY=0, and state goes to the resume state.
REQ-025 In LOAD, PREV, NEXT, TRACK_END and PLAY_TOGGLE are ignored. The lockout counter still decrements.
REQ-026 LOAD_ACK sampled outside LOAD has no effect.
REQ-027 LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, advances every cycle including in LOAD; it must never reach the all-zero state.
REQ-028 TRACK arithmetic is unsigned, modulo N; MODE changes take effect at the next evaluated event.

Reset
REQ-029 When RST=1 at a rising edge, regardless of state: state=IDLE, TRACK=0, LOAD_REQ=0, PLAYING=0, BUSY=0, resume=PLAY, lockout counter=0, LFSR=8'h5A.
REQ-030 RST asserted during LOAD abandons the request: LOAD_REQ=0 on the next edge, and a late LOAD_ACK has no effect.

Verification
REQ-031 Reset, MODE=1, PLAY_TOGGLE pulse -> next edge LOAD_REQ=1, BUSY=1, TRACK=0. LOAD_ACK held 1 for 1 cycle -> LOAD_REQ=0, PLAYING=1.
REQ-032 IDLE, TRACK=0, PREV held 3 cycles -> TRACK=7 after first edge, then unchanged. Release PREV, reassert NEXT at LOCKOUT-1 cycles -> ignored. NEXT at LOCKOUT+1 cycles -> TRACK=0.
REQ-033 PLAY, MODE=0, TRACK=7, TRACK_END pulse -> TRACK=0, state IDLE, PLAYING=0, LOAD_REQ stays 0. Same with MODE=1 -> TRACK=0, LOAD_REQ=1.
REQ-034 PLAY, MODE=2, TRACK=5, TRACK_END -> LOAD_REQ=1, TRACK=5. Same with MODE=3 -> TRACK≠5 over 200 iterations, and all 8 indices appear.
REQ-035 PAUSE, TRACK=2, NEXT -> LOAD_REQ=1, TRACK=3. Withhold LOAD_ACK 10 cycles with NEXT/TRACK_END pulses -> TRACK stays 3. ACK -> state PAUSE, PLAYING=0.
REQ-036 PLAY, same cycle NEXT+TRACK_END+PLAY_TOGGLE -> only NEXT acted on (TRACK+1, LOAD). RST during LOAD -> all outputs 0 next edge.

Source files
------------

// File: rtl/track_scheduler.sv
// track_scheduler: play/pause/seek sequencer with shuffle, button lockout and load handshake
module track_scheduler #(
    parameter int IDX_W   = 3,
    parameter int LOCKOUT = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prev,
    input  logic             next,
    input  logic             play_toggle,
    input  logic [1:0]       mode,
    input  logic             track_end,
    input  logic             load_ack,
    output logic [IDX_W-1:0] track,
    output logic             load_req,
    output logic             playing,
    output logic             busy
);
    localparam int CW = $clog2(LOCKOUT + 1);
    typedef enum logic [1:0] {IDLE, LOAD, PLAY, PAUSE} state_t;
    state_t           state, state_n;
    logic             resume, resume_n;
    logic [IDX_W-1:0] track_n, succ, cand;
    logic [CW-1:0]    cnt, cnt_n;
    logic [7:0]       lfsr;
    logic             seek;
    assign cand = lfsr[IDX_W-1:0];
    assign succ = (mode == 2'd3 && cand != track) ? cand : track + 1'b1;
    // free-running shuffle source, x^8+x^6+x^5+x^4+1, nonzero seed keeps it out of the lock-up state
    always_ff @(posedge clk)
        if (rst) lfsr <= 8'h5A;
        else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    // state, track, lockout and registered status outputs
    always_ff @(posedge clk)
        if (rst) begin
            state    <= IDLE;
            track    <= '0;
            resume   <= 1'b1;
            cnt      <= '0;
            load_req <= 1'b0;
            playing  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            track    <= track_n;
            resume   <= resume_n;
            cnt      <= cnt_n;
            load_req <= state_n == LOAD;
            playing  <= state_n == PLAY;
            busy     <= state_n == LOAD;
        end
    // one event per cycle: seek buttons, then track end, then play toggle; LOAD only waits for ack
    always_comb begin
        state_n  = state;
        track_n  = track;
        resume_n = resume;
        cnt_n    = (cnt == '0) ? cnt : cnt - 1'b1;
        seek     = (prev || next) && cnt == '0 && state != LOAD;
        if (state == LOAD) begin
            if (load_ack) state_n = resume ? PLAY : PAUSE;
        end else if (seek) begin
            track_n = prev ? track - 1'b1 : succ;
            cnt_n   = CW'(LOCKOUT);
            if (state != IDLE) begin
                state_n  = LOAD;
                resume_n = state == PLAY;
            end
        end else if (track_end && state == PLAY) begin
            if (mode == 2'd0 && &track) begin
                track_n = '0;
                state_n = IDLE;
            end else begin
                track_n  = (mode == 2'd2) ? track : succ;
                state_n  = LOAD;
                resume_n = 1'b1;
            end
        end else if (play_toggle) begin
            state_n  = (state == IDLE) ? LOAD : (state == PLAY) ? PAUSE : PLAY;
            resume_n = 1'b1;
        end
    end
endmodule

// File: tb/tb_track_scheduler.sv
// tb_track_scheduler: scoreboard bench for the track scheduler
module tb_track_scheduler;
    localparam int LK = 20;
    logic       clk = 0, rst = 0, prev = 0, next = 0, play_toggle = 0, track_end = 0, load_ack = 0;
    logic [1:0] mode = 0;
    logic [2:0] track;
    logic       load_req, playing, busy;
    logic [5:0] obs;
    int         checks = 0, failures = 0;
    typedef struct { string n; logic [5:0] v; } exp_t;
    exp_t q[$];
    exp_t e;
    assign obs = {track, load_req, playing, busy};

    track_scheduler #(.IDX_W(3), .LOCKOUT(LK)) dut (
        .clk(clk), .rst(rst), .prev(prev), .next(next), .play_toggle(play_toggle),
        .mode(mode), .track_end(track_end), .load_ack(load_ack),
        .track(track), .load_req(load_req), .playing(playing), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // reset, step to track t in IDLE with mode 0, then play (and optionally pause)
    task automatic setup(input int t, input bit pause);
        rst = 1; mode = 0; cyc(); rst = 0;
        for (int i = 0; i < t; i++) begin
            next = 1; cyc(); next = 0;
            repeat (LK) cyc();
        end
        play_toggle = 1; cyc(); play_toggle = 0;
        load_ack = 1; cyc(); load_ack = 0;
        if (pause) begin play_toggle = 1; cyc(); play_toggle = 0; end
    endtask

    task automatic test_reset();
        rst = 1; q.push_back('{"reset", 6'b000_000}); cyc(); rst = 0;
        e = q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.n, obs, e.v); end
    endtask

    task automatic test_play();
        rst = 1; cyc(); rst = 0; mode = 1;
        play_toggle = 1; q.push_back('{"play_load", {3'd0, 3'b101}}); cyc(); play_toggle = 0;
        e = q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.n, obs, e.v); end
        load_ack = 1; q.push_back('{"play_ack", {3'd0, 3'b010}}); cyc(); load_ack = 0;
        e = q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.n, obs, e.v); end
    endtask

    task automatic test_lockout();
        rst = 1; cyc(); rst = 0; mode = 0;
        prev = 1;
        for (int i = 0; i < 3; i++) begin
            q.push_back('{"prev_held", {3'd7, 3'b000}}); cyc();
            e = q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.n, obs, e.v); end
        end
        prev = 0;
        repeat (LK - 4) cyc();
        next = 1;
        for (int j = LK - 1; j <= LK + 1; j++) begin
            q.push_back('{$sformatf("next_at_%0d", j), {(j == LK + 1) ? 3'd0 : 3'd7, 3'b000}}); cyc();
            e = q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.n, obs, e.v); end
        end
        next = 0;
    endtask

    task automatic test_track_end_wrap();
        setup(7, 0); mode = 0;
        track_end = 1; q.push_back('{"end_m0_last", {3'd0, 3'b000}}); cyc(); track_end = 0;
        e = q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.n, obs, e.v); end
        setup(7, 0); mode = 1;
        track_end = 1; q.push_back('{"end_m1_last", {3'd0, 3'b101}}); cyc(); track_end = 0;
        e = q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.n, obs, e.v); end
    endtask

    task automatic test_repeat_shuffle();
        logic [2:0] old;
        logic [7:0] seen = 0;
        setup(5, 0); mode = 2;
        track_end = 1; q.push_back('{"end_m2", {3'd5, 3'b101}}); cyc(); track_end = 0;
        e = q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.n, obs, e.v); end
        load_ack = 1; q.push_back('{"m2_ack", {3'd5, 3'b010}}); cyc(); load_ack = 0;
        e = q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.n, obs, e.v); end
        mode = 3;
        for (int i = 0; i < 200; i++) begin
            old = track;
            track_end = 1; cyc(); track_end = 0;
            checks++;
            if (track === old || {load_req, playing, busy} !== 3'b101) begin
                failures++; $display("FAIL shuffle_%0d track=%0d prev_track=%0d lr/pl/bz=%b need new track and 101", i, track, old, {load_req, playing, busy});
            end
            seen[track] = 1'b1;
            load_ack = 1; cyc(); load_ack = 0;
        end
        checks++;
        if (seen !== 8'hFF) begin failures++; $display("FAIL shuffle_cover got=%b exp=11111111", seen); end
    endtask

    task automatic test_pause_load();
        setup(2, 1); mode = 0;
        next = 1; q.push_back('{"pause_next", {3'd3, 3'b101}}); cyc(); next = 0;
        e = q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.n, obs, e.v); end
        for (int i = 0; i < 10; i++) begin
            next = i[0]; track_end = ~i[0]; play_toggle = i[1];
            q.push_back('{$sformatf("hold_%0d", i), {3'd3, 3'b101}}); cyc();
            e = q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.n, obs, e.v); end
        end
        next = 0; track_end = 0; play_toggle = 0;
        load_ack = 1; q.push_back('{"pause_ack", {3'd3, 3'b000}}); cyc(); load_ack = 0;
        e = q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.n, obs, e.v); end
        play_toggle = 1; q.push_back('{"resume", {3'd3, 3'b010}}); cyc(); play_toggle = 0;
        e = q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.n, obs, e.v); end
    endtask

    task automatic test_back_to_back();
        setup(4, 0); mode = 2;
        next = 1; track_end = 1; play_toggle = 1;
        q.push_back('{"priority", {3'd5, 3'b101}}); cyc();
        next = 0; track_end = 0; play_toggle = 0;
        e = q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.n, obs, e.v); end
        rst = 1; load_ack = 1; q.push_back('{"rst_in_load", 6'b000_000}); cyc(); rst = 0;
        e = q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.n, obs, e.v); end
        q.push_back('{"late_ack", 6'b000_000}); cyc(); load_ack = 0;
        e = q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.n, obs, e.v); end
        prev = 1; next = 1; q.push_back('{"prev_over_next", {3'd7, 3'b000}}); cyc(); prev = 0; next = 0;
        e = q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.n, obs, e.v); end
        play_toggle = 1; q.push_back('{"idle_play", {3'd7, 3'b101}}); cyc(); play_toggle = 0;
        e = q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.n, obs, e.v); end
        load_ack = 1; q.push_back('{"ack_to_play", {3'd7, 3'b010}}); cyc();
        e = q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.n, obs, e.v); end
        q.push_back('{"ack_outside_load", {3'd7, 3'b010}}); cyc(); load_ack = 0;
        e = q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.n, obs, e.v); end
    endtask

    initial begin
        cyc();
        test_reset();
        test_play();
        test_lockout();
        test_track_end_wrap();
        test_repeat_shuffle();
        test_pause_load();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
